// File: rtl/tile_codec_pkg.sv
// Shared definitions for the tile stream packer: FSM states, header layout
// and the width helpers the top and the beat assembler size themselves with.
package tile_codec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CALC      = 3'd1,
        ST_HDR       = 3'd2,
        ST_PAY       = 3'd3,
        ST_BYP       = 3'd4,
        ST_HOLD_LAST = 3'd5
    } state_e;

    localparam int HDR_MODE_LSB = 0;
    localparam int HDR_MODE_W   = 3;
    localparam int HDR_FLAG_LSB = 3;

    localparam int DEF_TILE_SIZE  = 8;
    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_BEAT_BYTES = 32;

    function automatic int tile_n(input int tile_size);
        return tile_size * tile_size;
    endfunction

    function automatic int tot_w(input int num_ch, input int n);
        return $clog2(num_ch * n + 2);
    endfunction

    function automatic int beat_cnt_w(input int beat_bytes);
        return $clog2(beat_bytes) + 1;
    endfunction

endpackage

// File: rtl/tile_beat_assembler.sv
// Collects single bytes (or whole beats) into output beats. One beat is
// filled while the previous one waits for the downstream handshake.
module tile_beat_assembler
    import tile_codec_pkg::*;
#(
    parameter int BEAT_BYTES = DEF_BEAT_BYTES,
    localparam int CNT_W = beat_cnt_w(BEAT_BYTES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    byte_valid_i,
    input  logic [7:0]              byte_i,
    input  logic                    byte_last_i,
    input  logic                    beat_load_i,
    input  logic [BEAT_BYTES*8-1:0] beat_i,
    input  logic                    beat_last_i,
    output logic                    place_ready_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [BEAT_BYTES*8-1:0] data_o,
    output logic [CNT_W-1:0]        bytes_o,
    output logic                    last_o
);

    logic [BEAT_BYTES*8-1:0] acc_q, acc_d, out_data_q, out_data_d, merged;
    logic [CNT_W-1:0]        cnt_q, cnt_d, out_bytes_q, out_bytes_d;
    logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                    stall;

    // Nothing is placed while a presented beat is being held back.
    assign stall         = out_valid_q && !ready_i;
    assign place_ready_o = !stall;

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_bytes_d = out_bytes_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        merged      = acc_q;
        merged[int'(cnt_q)*8 +: 8] = byte_i;
        if (out_valid_q && ready_i) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (!stall) begin
            if (beat_load_i) begin
                out_data_d  = beat_i;
                out_bytes_d = CNT_W'(BEAT_BYTES);
                out_valid_d = 1'b1;
                out_last_d  = beat_last_i;
            end else if (byte_valid_i) begin
                if (cnt_q == CNT_W'(BEAT_BYTES - 1) || byte_last_i) begin
                    out_data_d  = merged;
                    out_bytes_d = cnt_q + 1'b1;
                    out_valid_d = 1'b1;
                    out_last_d  = byte_last_i;
                    acc_d       = '0;
                    cnt_d       = '0;
                end else begin
                    acc_d = merged;
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_bytes_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_bytes_q <= out_bytes_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign valid_o = out_valid_q;
    assign data_o  = out_data_q;
    assign bytes_o = out_bytes_q;
    assign last_o  = out_last_q;

endmodule

// File: rtl/tile_stream_packer.sv
// Packs one tile (header + per-channel compressed or raw payloads) into a
// beat stream; all-raw tiles skip the header and stream whole beats.
module tile_stream_packer
    import tile_codec_pkg::*;
#(
    parameter int TILE_SIZE  = DEF_TILE_SIZE,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int BEAT_BYTES = DEF_BEAT_BYTES,
    localparam int N     = tile_n(TILE_SIZE),
    localparam int TOT_W = tot_w(NUM_CH, N),
    localparam int BCW   = beat_cnt_w(BEAT_BYTES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [2:0]              i_mode,
    input  logic [NUM_CH*N*8-1:0]   i_comp,
    input  logic [NUM_CH*8-1:0]     i_comp_bytesize,
    input  logic [NUM_CH*N*8-1:0]   i_raw,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [BEAT_BYTES*8-1:0] o_data,
    output logic [BCW-1:0]          o_beat_bytes,
    output logic                    o_last,
    output logic [TOT_W-1:0]        o_tile_bytesize
);

    localparam int NBEATS = NUM_CH * N / BEAT_BYTES;
    localparam int BI_W   = $clog2(NBEATS + 1);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_e                state_q, state_d;
    logic                  ready_q, accept, bypass, place_rdy;
    logic [NUM_CH*N*8-1:0] comp_q, raw_q;
    logic [NUM_CH*8-1:0]   size_q;
    logic [2:0]            mode_q;
    logic [NUM_CH-1:0]     raw_f_q, raw_f_d;
    logic [TOT_W-1:0]      len_q [NUM_CH];
    logic [TOT_W-1:0]      len_d [NUM_CH];
    logic [TOT_W-1:0]      total_q, total_d, idx_q, idx_d, cur_len;
    logic [7:0]            hdr_q, hdr_d, pay_byte;
    logic [CH_W-1:0]       ch_q, ch_d, nxt_ch, first_ch;
    logic [BI_W-1:0]       beat_q, beat_d;
    logic                  cur_raw, nxt_found, first_found, end_ch;
    logic                  byte_vld, byte_last, beat_ld, beat_last;
    logic [7:0]            byte_dat;
    logic [BEAT_BYTES*8-1:0] beat_dat;

    assign accept  = i_valid && ready_q;
    assign o_ready = ready_q;

    // Sizes are compared at int width so oversize values fall into raw.
    always_comb begin : calc
        int sz;
        int sum;
        logic all_raw;
        sum     = 0;
        all_raw = 1'b1;
        raw_f_d = '0;
        hdr_d   = '0;
        hdr_d[HDR_MODE_LSB +: HDR_MODE_W] = mode_q;
        for (int c = 0; c < NUM_CH; c++) begin
            sz          = int'(size_q[c*8 +: 8]);
            raw_f_d[c]  = (sz >= N);
            len_d[c]    = raw_f_d[c] ? TOT_W'(N) : TOT_W'(sz);
            hdr_d[HDR_FLAG_LSB + c] = raw_f_d[c];
            all_raw     = all_raw & raw_f_d[c];
            sum         = sum + (raw_f_d[c] ? N : sz);
        end
        bypass  = all_raw;
        total_d = all_raw ? TOT_W'(NUM_CH * N) : TOT_W'(sum + 1);
    end

    always_comb begin : chan_sel
        cur_len     = '0;
        cur_raw     = 1'b0;
        nxt_found   = 1'b0;
        nxt_ch      = '0;
        first_found = 1'b0;
        first_ch    = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (ch_q == CH_W'(c)) begin
                cur_len = len_q[c];
                cur_raw = raw_f_q[c];
            end
            if (len_q[c] != '0) begin
                first_found = 1'b1;
                first_ch    = CH_W'(c);
                if (c > int'(ch_q)) begin
                    nxt_found = 1'b1;
                    nxt_ch    = CH_W'(c);
                end
            end
        end
        pay_byte = cur_raw ? raw_q[(int'(ch_q)*N + int'(idx_q))*8 +: 8]
                           : comp_q[(int'(ch_q)*N + int'(idx_q))*8 +: 8];
        end_ch   = (idx_q == cur_len - TOT_W'(1));
    end

    always_comb begin : fsm
        state_d   = state_q;
        ch_d      = ch_q;
        idx_d     = idx_q;
        beat_d    = beat_q;
        byte_vld  = 1'b0;
        byte_dat  = 8'h00;
        byte_last = 1'b0;
        beat_ld   = 1'b0;
        beat_last = (beat_q == BI_W'(NBEATS - 1));
        beat_dat  = raw_q[int'(beat_q)*BEAT_BYTES*8 +: BEAT_BYTES*8];
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_CALC;
            ST_CALC: begin
                state_d = bypass ? ST_BYP : ST_HDR;
                beat_d  = '0;
            end
            ST_HDR: begin
                byte_vld  = 1'b1;
                byte_dat  = hdr_q;
                byte_last = !first_found;
                if (place_rdy) begin
                    ch_d    = first_ch;
                    idx_d   = '0;
                    state_d = first_found ? ST_PAY : ST_HOLD_LAST;
                end
            end
            ST_PAY: begin
                byte_vld  = 1'b1;
                byte_dat  = pay_byte;
                byte_last = end_ch && !nxt_found;
                if (place_rdy) begin
                    if (!end_ch) begin
                        idx_d = idx_q + 1'b1;
                    end else if (nxt_found) begin
                        ch_d  = nxt_ch;
                        idx_d = '0;
                    end else begin
                        state_d = ST_HOLD_LAST;
                    end
                end
            end
            ST_BYP: begin
                beat_ld = 1'b1;
                if (place_rdy) begin
                    if (beat_last) state_d = ST_HOLD_LAST;
                    else           beat_d  = beat_q + 1'b1;
                end
            end
            ST_HOLD_LAST: if (o_valid && i_ready && o_last) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            comp_q  <= '0;
            raw_q   <= '0;
            size_q  <= '0;
            mode_q  <= '0;
            raw_f_q <= '0;
            len_q   <= '{default: '0};
            total_q <= '0;
            hdr_q   <= '0;
            ch_q    <= '0;
            idx_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_IDLE);
            if (accept) begin
                comp_q <= i_comp;
                raw_q  <= i_raw;
                size_q <= i_comp_bytesize;
                mode_q <= i_mode;
            end
            if (state_q == ST_CALC) begin
                raw_f_q <= raw_f_d;
                len_q   <= len_d;
                total_q <= total_d;
                hdr_q   <= hdr_d;
            end
            ch_q   <= ch_d;
            idx_q  <= idx_d;
            beat_q <= beat_d;
        end
    end

    assign o_tile_bytesize = total_q;

    tile_beat_assembler #(.BEAT_BYTES(BEAT_BYTES)) u_asm (
        .clk          (clk),
        .rst          (rst),
        .byte_valid_i (byte_vld),
        .byte_i       (byte_dat),
        .byte_last_i  (byte_last),
        .beat_load_i  (beat_ld),
        .beat_i       (beat_dat),
        .beat_last_i  (beat_last),
        .place_ready_o(place_rdy),
        .valid_o      (o_valid),
        .ready_i      (i_ready),
        .data_o       (o_data),
        .bytes_o      (o_beat_bytes),
        .last_o       (o_last)
    );

endmodule

// File: tb/tb_tile_stream_packer.sv
// Directed bench for tile_stream_packer: default build plus a 3-channel,
// 4x4-tile, 4-byte-beat build, checked against a byte-list model.
module tb_tile_stream_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          i_ready;

    logic          i_valid, o_ready;
    logic [2:0]    i_mode;
    logic [2047:0] i_comp, i_raw;
    logic [31:0]   i_comp_bytesize;
    logic          o_valid, o_last;
    logic [255:0]  o_data;
    logic [5:0]    o_beat_bytes;
    logic [8:0]    o_tile_bytesize;

    logic          i_valid3, o_ready3;
    logic [2:0]    i_mode3;
    logic [383:0]  i_comp3, i_raw3;
    logic [23:0]   i_size3;
    logic          o_valid3, o_last3;
    logic [31:0]   o_data3;
    logic [2:0]    o_beat_bytes3;
    logic [5:0]    o_tile_bytesize3;

    tile_stream_packer dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_mode(i_mode),
        .i_comp(i_comp), .i_comp_bytesize(i_comp_bytesize), .i_raw(i_raw),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_beat_bytes(o_beat_bytes), .o_last(o_last), .o_tile_bytesize(o_tile_bytesize)
    );

    tile_stream_packer #(.TILE_SIZE(4), .NUM_CH(3), .BEAT_BYTES(4)) dut3 (
        .clk(clk), .rst(rst), .i_valid(i_valid3), .o_ready(o_ready3), .i_mode(i_mode3),
        .i_comp(i_comp3), .i_comp_bytesize(i_size3), .i_raw(i_raw3),
        .o_valid(o_valid3), .i_ready(i_ready), .o_data(o_data3),
        .o_beat_bytes(o_beat_bytes3), .o_last(o_last3), .o_tile_bytesize(o_tile_bytesize3)
    );

    int errors = 0;
    int checks = 0;

    int           sel = 0;
    logic         v_valid, v_last, v_ready;
    logic [255:0] v_data;
    int           v_bytes, v_total;

    always_comb begin
        if (sel == 0) begin
            v_valid = o_valid;  v_last = o_last;  v_ready = o_ready;
            v_data  = o_data;   v_bytes = int'(o_beat_bytes);  v_total = int'(o_tile_bytesize);
        end else begin
            v_valid = o_valid3; v_last = o_last3; v_ready = o_ready3;
            v_data  = {224'd0, o_data3};
            v_bytes = int'(o_beat_bytes3); v_total = int'(o_tile_bytesize3);
        end
    end

    logic [7:0] exp_q[$];
    logic [7:0] first_byte;
    int         tot_obs, nbeats, gaps, last_bytes;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [7:0] comp_b(input int c, input int k);
        return 8'((c * 37 + k * 3 + 1) % 256);
    endfunction

    function automatic logic [7:0] raw_b(input int c, input int k);
        return 8'((c * 53 + k * 7 + 2) % 256);
    endfunction

    // Drive the selected DUT's tile inputs and build the expected stream.
    task automatic setup(input int s, input int sz[5], input logic [2:0] mode);
        int nch, n, cnt;
        logic [7:0] hdr;
        bit all_raw, f;
        sel = s;
        nch = (s == 0) ? 4 : 3;
        n   = (s == 0) ? 64 : 16;
        for (int c = 0; c < nch; c++) begin
            for (int k = 0; k < n; k++) begin
                if (s == 0) begin
                    i_comp[(c*64+k)*8 +: 8] = comp_b(c, k);
                    i_raw[(c*64+k)*8 +: 8]  = raw_b(c, k);
                end else begin
                    i_comp3[(c*16+k)*8 +: 8] = comp_b(c, k);
                    i_raw3[(c*16+k)*8 +: 8]  = raw_b(c, k);
                end
            end
            if (s == 0) i_comp_bytesize[c*8 +: 8] = 8'(sz[c]);
            else        i_size3[c*8 +: 8]         = 8'(sz[c]);
        end
        if (s == 0) i_mode = mode; else i_mode3 = mode;
        exp_q.delete();
        hdr = {5'b0, mode};
        all_raw = 1'b1;
        for (int c = 0; c < nch; c++) begin
            f = (sz[c] >= n);
            if (f) hdr[3+c] = 1'b1; else all_raw = 1'b0;
        end
        if (all_raw) begin
            for (int c = 0; c < nch; c++)
                for (int k = 0; k < n; k++) exp_q.push_back(raw_b(c, k));
        end else begin
            exp_q.push_back(hdr);
            for (int c = 0; c < nch; c++) begin
                f   = (sz[c] >= n);
                cnt = f ? n : sz[c];
                for (int k = 0; k < cnt; k++) exp_q.push_back(f ? raw_b(c, k) : comp_b(c, k));
            end
        end
    endtask

    task automatic send();
        bit acc = 1'b0;
        @(negedge clk);
        if (sel == 0) i_valid = 1'b1; else i_valid3 = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            if (v_ready) acc = 1'b1;
            @(negedge clk);
        end
        i_valid  = 1'b0;
        i_valid3 = 1'b0;
        chk("accept", 32'(acc), 1);
        chk("ready_low_busy", 32'(v_ready), 0);
    endtask

    task automatic collect(input int bb, input bit toggle);
        int pos = 0, rem, expb;
        bit done = 1'b0, prev_stall = 1'b0, rdy;
        logic [255:0] sv_data;
        int sv_bytes, sv_total;
        logic sv_last;
        nbeats = 0; gaps = 0; last_bytes = 0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            @(negedge clk);
            if (prev_stall)
                chk("stall_hold", {27'd0, v_valid, v_data === sv_data, v_bytes == sv_bytes,
                                   v_last === sv_last, v_total == sv_total}, 32'h1f);
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            i_ready = rdy;
            if (v_valid && rdy) begin
                rem  = exp_q.size() - pos;
                expb = (rem < bb) ? rem : bb;
                chk("beat_bytes", v_bytes, expb);
                chk("beat_last", 32'(v_last), 32'(rem <= bb));
                chk("tile_bytesize", v_total, exp_q.size());
                for (int j = 0; j < bb; j++)
                    chk("beat_byte", v_data[j*8 +: 8],
                        (j < expb && pos + j < exp_q.size()) ? exp_q[pos+j] : 8'h00);
                if (nbeats == 0) begin
                    first_byte = v_data[7:0];
                    tot_obs    = v_total;
                end
                last_bytes = v_bytes;
                pos += expb;
                nbeats++;
                done = v_last || pos >= exp_q.size();
            end else if (nbeats > 0 && !v_valid) begin
                gaps++;
            end
            prev_stall = v_valid && !rdy;
            sv_data = v_data; sv_bytes = v_bytes; sv_last = v_last; sv_total = v_total;
        end
        chk("collect_done", 32'(done), 1);
        i_ready = 1'b1;
        @(negedge clk);
        chk("ready_after_tile", 32'(v_ready), 1);
        chk("idle_no_valid", 32'(v_valid), 0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1; i_ready = 1'b1;
        i_valid = 1'b0; i_mode = '0; i_comp = '0; i_raw = '0; i_comp_bytesize = '0;
        i_valid3 = 1'b0; i_mode3 = '0; i_comp3 = '0; i_raw3 = '0; i_size3 = '0;
        #1;
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_ready", 32'(o_ready), 0);
        chk("rst_last", 32'(o_last), 0);
        chk("rst_data", 32'(|o_data), 0);
        chk("rst_beat_bytes", 32'(o_beat_bytes), 0);
        chk("rst_tile_bytesize", 32'(o_tile_bytesize), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1 chk("ready_held_low", 32'(o_ready), 0);
        @(negedge clk);
        chk("ready_after_rst", 32'(o_ready), 1);

        // Mixed compressed sizes, unstalled.
        setup(0, '{10, 20, 30, 5, 0}, 3'b101);
        send(); collect(32, 1'b0);
        chk("a_header", first_byte, 8'h05);
        chk("a_total", tot_obs, 66);
        chk("a_beats", nbeats, 3);
        chk("a_last_bytes", last_bytes, 2);

        // All channels raw: bypass.
        setup(0, '{64, 64, 64, 64, 0}, 3'b010);
        send(); collect(32, 1'b0);
        chk("b_first_byte", first_byte, raw_b(0, 0));
        chk("b_total", tot_obs, 256);
        chk("b_beats", nbeats, 8);
        chk("b_gaps", gaps, 0);

        // Oversize treated as raw, zero-size channel skipped.
        setup(0, '{70, 3, 0, 64, 0}, 3'b000);
        send(); collect(32, 1'b0);
        chk("c_header", first_byte, 8'h48);
        chk("c_total", tot_obs, 132);
        chk("c_beats", nbeats, 5);

        // Same tile as the first case with i_ready toggling.
        setup(0, '{10, 20, 30, 5, 0}, 3'b101);
        send(); collect(32, 1'b1);
        chk("d_header", first_byte, 8'h05);
        chk("d_total", tot_obs, 66);
        chk("d_beats", nbeats, 3);

        // Reset while a beat is held mid-payload.
        setup(0, '{10, 20, 30, 5, 0}, 3'b101);
        send();
        i_ready = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        chk("e_valid_before_rst", 32'(seen), 1);
        rst = 1'b1;
        #1;
        chk("e_rst_valid", 32'(o_valid), 0);
        chk("e_rst_ready", 32'(o_ready), 0);
        chk("e_rst_data", 32'(|o_data), 0);
        chk("e_rst_beat_bytes", 32'(o_beat_bytes), 0);
        @(negedge clk);
        rst = 1'b0; i_ready = 1'b1;
        #1 chk("e_ready_held_low", 32'(o_ready), 0);
        @(negedge clk);
        chk("e_ready_after_rst", 32'(o_ready), 1);
        chk("e_no_partial", 32'(o_valid), 0);
        setup(0, '{70, 3, 0, 64, 0}, 3'b110);
        send(); collect(32, 1'b0);
        chk("e_header", first_byte, 8'h4e);
        chk("e_total", tot_obs, 132);

        // Small build: 3 channels, 4x4 tile, 4-byte beats.
        setup(1, '{16, 2, 1, 0, 0}, 3'b011);
        send(); collect(4, 1'b0);
        chk("f_header", first_byte, 8'h0b);
        chk("f_total", tot_obs, 20);
        chk("f_beats", nbeats, 5);
        chk("f_last_bytes", last_bytes, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
